me_fetch: RTL and testbench

- Pixel fetch controller directly upstream of the motion-estimation core (ME).
- Serves ME's level requests need_cur and need_ref from a single-port frame memory.
  - need_cur returns 4 current-frame pixels per 32-bit word.
  - need_ref returns 8 padded-reference pixels per 64-bit word.
- Walks blocks in raster order over the frame.
- Generates all addresses and delivers registered cur_in/ref_in with valid strobes.

---
 rtl/me_pkg.sv | 36 +++
 rtl/me_addr_gen.sv | 57 +++++
 rtl/me_fetch.sv | 173 +++++++++++++++++
 tb/tb_me_fetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and geometry helpers for the motion-estimation pixel fetch block.
package me_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } me_state_e;

  localparam int PIX_W  = 8;
  localparam int CUR_DW = 32;
  localparam int REF_DW = 64;
  localparam int CUR_WB = CUR_DW / PIX_W;
  localparam int REF_WB = REF_DW / PIX_W;

  function automatic int win_of(input int blk, input int sr);
    return blk + 2 * sr;
  endfunction

  function automatic int cur_wpr_of(input int blk);
    return blk / CUR_WB;
  endfunction

  function automatic int ref_wpr_of(input int blk, input int sr);
    return win_of(blk, sr) / REF_WB;
  endfunction

  function automatic int ref_stride_of(input int frame_w, input int sr);
    return frame_w + 2 * sr;
  endfunction

  function automatic int blk_cnt_of(input int dim, input int blk);
    return dim / blk;
  endfunction

endpackage

// File: rtl/me_addr_gen.sv
// Word walker over one rectangular pixel set: column/row counters, remaining flag
// and the byte address of the word that the next accept will read.
module me_addr_gen
  import me_pkg::*;
#(
  parameter int WPR    = 4,
  parameter int ROWS   = 16,
  parameter int STRIDE = 64,
  parameter int WB     = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        step,
  input  logic [31:0] base,
  output logic        remaining,
  output logic [31:0] addr
);

  localparam int CW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WPR - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic          rem_r;

  // advance one word per accept; the final word of the set drops remaining
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
      rem_r <= 1'b0;
    end else if (clr) begin
      col_r <= '0;
      row_r <= '0;
      rem_r <= 1'b1;
    end else if (step && rem_r) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        if (row_r == ROW_LAST) begin
          row_r <= '0;
          rem_r <= 1'b0;
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  assign remaining = rem_r;
  assign addr      = base + 32'(row_r) * 32'(STRIDE) + 32'(col_r) * 32'(WB);

endmodule

// File: rtl/me_fetch.sv
// Pixel fetch controller feeding the ME core from a single-port frame memory.
// Define ME_FETCH_STAT_EN to add the rd_cnt read statistics output.
module me_fetch
  import me_pkg::*;
#(
  parameter int          FRAME_W  = 3840,
  parameter int          FRAME_H  = 2160,
  parameter int          BLK      = 16,
  parameter int          SR       = 16,
  parameter logic [31:0] CUR_BASE = 32'd0,
  parameter logic [31:0] REF_BASE = 32'd0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              need_cur,
  input  logic              need_ref,
  output logic              cur_ack,
  output logic              ref_ack,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  input  logic [REF_DW-1:0] mem_rdata,
  output logic [CUR_DW-1:0] cur_in,
  output logic [REF_DW-1:0] ref_in,
  output logic              cur_vld,
  output logic              ref_vld,
  output logic              blk_done,
  output logic              frame_done,
  output logic              busy,
  output logic              err
`ifdef ME_FETCH_STAT_EN
  ,
  output logic [31:0]       rd_cnt
`endif
);

  localparam int WIN        = win_of(BLK, SR);
  localparam int CUR_WPR    = cur_wpr_of(BLK);
  localparam int REF_WPR    = ref_wpr_of(BLK, SR);
  localparam int REF_STRIDE = ref_stride_of(FRAME_W, SR);
  localparam int BLK_X      = blk_cnt_of(FRAME_W, BLK);
  localparam int BLK_Y      = blk_cnt_of(FRAME_H, BLK);
  localparam int BXW        = (BLK_X > 1) ? $clog2(BLK_X) : 1;
  localparam int BYW        = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;
  localparam logic [BXW-1:0] BX_LAST = BXW'(BLK_X - 1);
  localparam logic [BYW-1:0] BY_LAST = BYW'(BLK_Y - 1);

  me_state_e          state_r, state_nx_s;
  logic [BXW-1:0]     bx_r;
  logic [BYW-1:0]     by_r;
  logic               cur_rem_s, ref_rem_s;
  logic [31:0]        cur_addr_s, ref_addr_s, cur_base_s, ref_base_s;
  logic               cur_ack_s, ref_ack_s, blk_done_s, start_go_s, err_set_s;
  logic               last_blk_s, gen_clr_s;
  logic               pend_cur_r, pend_ref_r, cur_vld_r, ref_vld_r, err_r;
  logic [CUR_DW-1:0]  cur_in_r;
  logic [REF_DW-1:0]  ref_in_r;

  assign last_blk_s = (bx_r == BX_LAST) && (by_r == BY_LAST);
  assign gen_clr_s  = start_go_s | (blk_done_s & ~last_blk_s);
  assign cur_base_s = CUR_BASE + 32'(by_r) * 32'(BLK * FRAME_W) + 32'(bx_r) * 32'(BLK);
  assign ref_base_s = REF_BASE + 32'(by_r) * 32'(BLK * REF_STRIDE) + 32'(bx_r) * 32'(BLK);

  me_addr_gen #(.WPR(CUR_WPR), .ROWS(BLK), .STRIDE(FRAME_W), .WB(CUR_WB)) u_cur_gen (
    .clk(clk), .rst(rst), .clr(gen_clr_s), .step(cur_ack_s),
    .base(cur_base_s), .remaining(cur_rem_s), .addr(cur_addr_s)
  );

  me_addr_gen #(.WPR(REF_WPR), .ROWS(WIN), .STRIDE(REF_STRIDE), .WB(REF_WB)) u_ref_gen (
    .clk(clk), .rst(rst), .clr(gen_clr_s), .step(ref_ack_s),
    .base(ref_base_s), .remaining(ref_rem_s), .addr(ref_addr_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // next state, arbitration (cur wins) and error detection
  always_comb begin
    state_nx_s = state_r;
    cur_ack_s  = 1'b0;
    ref_ack_s  = 1'b0;
    blk_done_s = 1'b0;
    start_go_s = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_go_s = start;
        err_set_s  = need_cur | need_ref;
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        cur_ack_s  = need_cur & cur_rem_s;
        ref_ack_s  = need_ref & ref_rem_s & ~cur_ack_s;
        blk_done_s = ~cur_rem_s & ~ref_rem_s;
        err_set_s  = (need_cur & ~cur_rem_s & ~ref_ack_s) | (need_ref & ~ref_rem_s);
        if (blk_done_s && last_blk_s) state_nx_s = ST_DONE;
        else                          state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        err_set_s  = need_cur | need_ref;
        state_nx_s = ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // block position in raster order
  always_ff @(posedge clk) begin
    if (rst || start_go_s) begin
      bx_r <= '0;
      by_r <= '0;
    end else if (blk_done_s) begin
      if (bx_r == BX_LAST) begin
        bx_r <= '0;
        by_r <= (by_r == BY_LAST) ? '0 : by_r + BYW'(1);
      end else begin
        bx_r <= bx_r + BXW'(1);
      end
    end
  end

  // read data pipeline: accept, sample rdata next cycle, present the cycle after
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cur_r <= 1'b0;
      pend_ref_r <= 1'b0;
      cur_vld_r  <= 1'b0;
      ref_vld_r  <= 1'b0;
      cur_in_r   <= '0;
      ref_in_r   <= '0;
      err_r      <= 1'b0;
    end else begin
      pend_cur_r <= cur_ack_s;
      pend_ref_r <= ref_ack_s;
      cur_vld_r  <= pend_cur_r;
      ref_vld_r  <= pend_ref_r;
      if (pend_cur_r) cur_in_r <= mem_rdata[CUR_DW-1:0];
      if (pend_ref_r) ref_in_r <= mem_rdata;
      if (err_set_s)  err_r    <= 1'b1;
    end
  end

`ifdef ME_FETCH_STAT_EN
  logic [31:0] rd_cnt_r;

  // saturating count of memory reads since the last start
  always_ff @(posedge clk) begin
    if (rst || start_go_s)                     rd_cnt_r <= 32'd0;
    else if (mem_rd && rd_cnt_r != 32'hFFFF_FFFF) rd_cnt_r <= rd_cnt_r + 32'd1;
    else                                       rd_cnt_r <= rd_cnt_r;
  end

  assign rd_cnt = rd_cnt_r;
`endif

  assign cur_ack    = cur_ack_s;
  assign ref_ack    = ref_ack_s;
  assign mem_rd     = cur_ack_s | ref_ack_s;
  assign mem_addr   = cur_ack_s ? cur_addr_s : (ref_ack_s ? ref_addr_s : 32'd0);
  assign cur_in     = cur_in_r;
  assign ref_in     = ref_in_r;
  assign cur_vld    = cur_vld_r;
  assign ref_vld    = ref_vld_r;
  assign blk_done   = blk_done_s;
  assign frame_done = (state_r == ST_DONE);
  assign busy       = (state_r == ST_RUN);
  assign err        = err_r;

endmodule

// File: tb/tb_me_fetch.sv
// Scoreboard bench for me_fetch on a 64x32 frame (4x2 blocks of 16, SR 16).
module tb_me_fetch;

  localparam int FW = 64, FH = 32, BLK = 16, SR = 16;
  localparam int CUR_N = 64, REF_N = 288;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, need_cur = 1'b0, need_ref = 1'b0;
  logic        cur_ack, ref_ack, mem_rd, cur_vld, ref_vld, blk_done, frame_done, busy, err;
  logic [31:0] mem_addr, cur_in;
  logic [63:0] mem_rdata = 64'd0, ref_in;
`ifdef ME_FETCH_STAT_EN
  logic [31:0] rd_cnt;
`endif

  typedef struct { logic [63:0] d; int t; } exp_t;
  exp_t cur_q[$], ref_q[$];
  int checks = 0, errors = 0, cyc_n = 0;

  logic        run_m = 1'b0, done_m = 1'b0, err_m = 1'b0;
  int          bx_m = 0, by_m = 0, cur_cnt = 0, ref_cnt = 0;
  logic [31:0] first_cur[8], first_ref[8], last_cur[8], last_ref[8], cur_log[5];
  logic        rd_cap = 1'b0;
  logic [31:0] addr_cap = 32'd0;
  logic [63:0] cur_hold = 64'd0, ref_hold = 64'd0;

  me_fetch #(.FRAME_W(FW), .FRAME_H(FH), .BLK(BLK), .SR(SR),
             .CUR_BASE(32'd0), .REF_BASE(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .need_cur(need_cur), .need_ref(need_ref),
    .cur_ack(cur_ack), .ref_ack(ref_ack), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .cur_in(cur_in), .ref_in(ref_in), .cur_vld(cur_vld),
    .ref_vld(ref_vld), .blk_done(blk_done), .frame_done(frame_done), .busy(busy),
    .err(err)
`ifdef ME_FETCH_STAT_EN
    , .rd_cnt(rd_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [63:0] mem_f(input logic [31:0] a);
    return {a ^ 32'hC3C3_0000, a ^ 32'h0000_5A5A};
  endfunction

  function automatic logic [31:0] cur_addr_m(input int bx, input int by, input int n);
    return 32'((by * BLK + n / 4) * FW + bx * BLK + (n % 4) * 4);
  endfunction

  function automatic logic [31:0] ref_addr_m(input int bx, input int by, input int n);
    return 32'((by * BLK + n / 6) * (FW + 2 * SR) + bx * BLK + (n % 6) * 8);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // memory responder: data for a read issued in cycle N is on the bus during N+1
  always @(negedge clk) begin
    rd_cap   = mem_rd;
    addr_cap = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_cap ? mem_f(addr_cap) : 64'd0;
  end

  // monitor: pop expected word whenever a vld strobe appears, else check hold
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_q.delete();
      ref_q.delete();
      cur_hold = 64'd0;
      ref_hold = 64'd0;
    end else begin
      if (cur_vld) begin
        if (cur_q.size() == 0) chk("cur_vld_unexpected", 64'd1, 64'd0);
        else begin
          e = cur_q.pop_front();
          chk("cur_in", {32'd0, cur_in}, e.d);
          chk("cur_latency", 64'(cyc_n), 64'(e.t));
        end
        cur_hold = {32'd0, cur_in};
      end else chk("cur_hold", {32'd0, cur_in}, cur_hold);
      if (ref_vld) begin
        if (ref_q.size() == 0) chk("ref_vld_unexpected", 64'd1, 64'd0);
        else begin
          e = ref_q.pop_front();
          chk("ref_in", ref_in, e.d);
          chk("ref_latency", 64'(cyc_n), 64'(e.t));
        end
        ref_hold = ref_in;
      end else chk("ref_hold", ref_in, ref_hold);
    end
  end

  // one clock of stimulus plus reference-model prediction of the control outputs
  task automatic cyc(input logic nc, input logic nr, input logic st);
    logic ec, er, eb, idle;
    logic [31:0] a;
    logic [63:0] d;
    int idx;
    need_cur = nc; need_ref = nr; start = st;
    @(negedge clk);
    idle = !run_m && !done_m;
    eb = run_m && cur_cnt == CUR_N && ref_cnt == REF_N;
    ec = run_m && nc && cur_cnt < CUR_N;
    er = run_m && nr && ref_cnt < REF_N && !ec;
    idx = bx_m + 4 * by_m;
    chk("cur_ack", {63'd0, cur_ack}, {63'd0, ec});
    chk("ref_ack", {63'd0, ref_ack}, {63'd0, er});
    chk("mem_rd", {63'd0, mem_rd}, {63'd0, ec | er});
    chk("blk_done", {63'd0, blk_done}, {63'd0, eb});
    chk("frame_done", {63'd0, frame_done}, {63'd0, done_m});
    chk("busy", {63'd0, busy}, {63'd0, run_m});
    chk("err", {63'd0, err}, {63'd0, err_m});
    if (ec) begin
      a = cur_addr_m(bx_m, by_m, cur_cnt);
      chk("cur_addr", {32'd0, mem_addr}, {32'd0, a});
      d = mem_f(a);
      cur_q.push_back('{d: {32'd0, d[31:0]}, t: cyc_n + 2});
      if (cur_cnt == 0) first_cur[idx] = mem_addr;
      if (cur_cnt == CUR_N - 1) last_cur[idx] = mem_addr;
      if (idx == 0 && cur_cnt < 5) cur_log[cur_cnt] = mem_addr;
      cur_cnt++;
    end
    if (er) begin
      a = ref_addr_m(bx_m, by_m, ref_cnt);
      chk("ref_addr", {32'd0, mem_addr}, {32'd0, a});
      ref_q.push_back('{d: mem_f(a), t: cyc_n + 2});
      if (ref_cnt == 0) first_ref[idx] = mem_addr;
      if (ref_cnt == REF_N - 1) last_ref[idx] = mem_addr;
      ref_cnt++;
    end
    if ((!run_m && (nc || nr)) || (run_m && nc && cur_cnt >= CUR_N && !er && !ec) ||
        (run_m && nr && ref_cnt >= REF_N && !ec && !er)) err_m = 1'b1;
    if (done_m) done_m = 1'b0;
    else if (eb) begin
      cur_cnt = 0; ref_cnt = 0;
      if (bx_m == 3 && by_m == 1) begin
        run_m = 1'b0; done_m = 1'b1; bx_m = 0; by_m = 0;
      end else if (bx_m == 3) begin
        bx_m = 0; by_m++;
      end else bx_m++;
    end
    if (st && idle) begin
      run_m = 1'b1; bx_m = 0; by_m = 0; cur_cnt = 0; ref_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cur_in", {32'd0, cur_in}, 64'd0);
    chk("rst_ref_in", ref_in, 64'd0);
    chk("rst_vld", {62'd0, cur_vld, ref_vld}, 64'd0);
    chk("rst_flags", {60'd0, busy, err, blk_done, frame_done}, 64'd0);
    chk("rst_mem", {31'd0, mem_rd, mem_addr}, 64'd0);
    @(posedge clk);
    #1;

    cyc(1'b0, 1'b0, 1'b1);
    repeat (CUR_N) cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("cur_addr0", {32'd0, cur_log[0]}, 64'd0);
    chk("cur_addr1", {32'd0, cur_log[1]}, 64'd4);
    chk("cur_addr3", {32'd0, cur_log[3]}, 64'd12);
    chk("cur_addr4", {32'd0, cur_log[4]}, 64'd64);
    chk("cur_last_b0", {32'd0, last_cur[0]}, 64'd972);
    repeat (REF_N) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ref_first_b0", {32'd0, first_ref[0]}, 64'd0);
    chk("ref_last_b0", {32'd0, last_ref[0]}, 64'd4552);

    for (int b = 1; b < 8; b++) begin
      for (int k = 0; k < CUR_N + REF_N; k++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("cur_first_b1", {32'd0, first_cur[1]}, 64'd16);
    chk("ref_first_b1", {32'd0, first_ref[1]}, 64'd16);
    chk("cur_first_b4", {32'd0, first_cur[4]}, 64'd1024);
    chk("ref_first_b4", {32'd0, first_ref[4]}, 64'd1536);
    chk("cur_last_b7", {32'd0, last_cur[7]}, 64'd2044);
    chk("ref_last_b7", {32'd0, last_ref[7]}, 64'd6136);
    chk("busy_after_frame", {63'd0, busy}, 64'd0);
    chk("err_before_extra", {63'd0, err}, 64'd0);
`ifdef ME_FETCH_STAT_EN
    chk("rd_cnt", {32'd0, rd_cnt}, 64'd2816);
`endif
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("err_idle_need", {63'd0, err}, 64'd1);

    // reset while a read is in flight
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    need_cur = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    run_m = 1'b0; done_m = 1'b0; err_m = 1'b0;
    bx_m = 0; by_m = 0; cur_cnt = 0; ref_cnt = 0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_cur_in", {32'd0, cur_in}, 64'd0);
    chk("post_rst_err", {63'd0, err}, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    first_cur[0] = 32'hFFFF_FFFF;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_addr", {32'd0, first_cur[0]}, 64'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("queues_drained", 64'(cur_q.size() + ref_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
